// File: rtl/cart_bus_pkg.sv
// rtl/cart_bus_pkg.sv - shared types and constants for the cartridge bus arbiter
package cart_bus_pkg;

  typedef enum logic [2:0] {
    ST_CORE,
    ST_HALT,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_ACK,
    ST_DBG_IDLE
  } state_e;

  localparam logic [15:0] CART_RAM_BASE = 16'hA000;

  localparam int DEF_HALT_SETTLE    = 2;
  localparam int DEF_SETUP_CYCLES   = 2;
  localparam int DEF_STROBE_CYCLES  = 4;
  localparam int DEF_HOLD_CYCLES    = 1;
  localparam int DEF_HOLDOFF_CYCLES = 8;

  function automatic int max5(input int a, input int b, input int c, input int d, input int e);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    if (e > m) m = e;
    return m;
  endfunction

endpackage

// File: rtl/cart_bus_arbiter_phase_timer.sv
// rtl/cart_bus_arbiter_phase_timer.sv - loadable down-counter flagging the last cycle of a phase
module phase_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A phase loaded with N spends N cycles; done marks the Nth.
  assign done = (cnt_q == W'(1));

endmodule

// File: rtl/cart_bus_arbiter.sv
// rtl/cart_bus_arbiter.sv - shares the cartridge bus between the core and a debug requester
module cart_bus_arbiter
  import cart_bus_pkg::*;
#(
  parameter int HALT_SETTLE    = DEF_HALT_SETTLE,
  parameter int SETUP_CYCLES   = DEF_SETUP_CYCLES,
  parameter int STROBE_CYCLES  = DEF_STROBE_CYCLES,
  parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES,
  parameter int HOLDOFF_CYCLES = DEF_HOLDOFF_CYCLES
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] core_a,
  input  logic [7:0]  core_dout,
  input  logic        core_rd,
  input  logic        core_wr,
  output logic [7:0]  core_din,
  output logic        core_halt,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [15:0] dbg_addr,
  input  logic [7:0]  dbg_wdata,
  output logic        dbg_ack,
  output logic [7:0]  dbg_rdata,
  output logic [15:0] cart_a,
  output logic [7:0]  cart_dout,
  output logic        cart_oe,
  input  logic [7:0]  cart_din,
  output logic        cart_rd,
  output logic        cart_wr,
  output logic        cart_cs
);

  localparam int MAXP = max5(HALT_SETTLE, SETUP_CYCLES, STROBE_CYCLES, HOLD_CYCLES, HOLDOFF_CYCLES);
  localparam int CW   = $clog2(MAXP + 1);

  localparam logic [CW-1:0] L_SETTLE  = CW'(HALT_SETTLE);
  localparam logic [CW-1:0] L_SETUP   = CW'(SETUP_CYCLES);
  localparam logic [CW-1:0] L_STROBE  = CW'(STROBE_CYCLES);
  localparam logic [CW-1:0] L_HOLD    = CW'(HOLD_CYCLES);
  localparam logic [CW-1:0] L_HOLDOFF = CW'(HOLDOFF_CYCLES);

  state_e        state_q, state_d;
  logic          we_q, we_d;
  logic [15:0]   addr_q, addr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic          pend_q, pend_d;
  logic [7:0]    rdata_q, rdata_d;
  logic          ack_q, ack_d;
  logic          halt_q, halt_d;
  logic [15:0]   cart_a_q, cart_a_d;
  logic [7:0]    cart_dout_q, cart_dout_d;
  logic          cart_oe_q, cart_oe_d;
  logic          cart_rd_q, cart_rd_d;
  logic          cart_wr_q, cart_wr_d;
  logic          cart_cs_q, cart_cs_d;

  logic          tmr_load;
  logic [CW-1:0] tmr_val;
  logic          tmr_done;

  phase_timer #(.W(CW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    pend_d   = pend_q;
    rdata_d  = rdata_q;
    tmr_load = 1'b0;
    tmr_val  = L_SETTLE;

    case (state_q)
      ST_CORE: begin
        if (dbg_req) begin
          state_d  = ST_HALT;
          tmr_load = 1'b1;
          tmr_val  = L_SETTLE;
        end
      end
      ST_HALT: begin
        if (core_rd || core_wr) begin
          tmr_load = 1'b1;
          tmr_val  = L_SETTLE;
        end else if (tmr_done) begin
          state_d  = ST_SETUP;
          we_d     = dbg_we;
          addr_d   = dbg_addr;
          wdata_d  = dbg_wdata;
          tmr_load = 1'b1;
          tmr_val  = L_SETUP;
        end
      end
      ST_SETUP: begin
        if (tmr_done) begin
          state_d  = ST_STROBE;
          tmr_load = 1'b1;
          tmr_val  = L_STROBE;
        end
      end
      ST_STROBE: begin
        if (tmr_done) begin
          if (!we_q) rdata_d = cart_din;
          state_d  = ST_HOLD;
          tmr_load = 1'b1;
          tmr_val  = L_HOLD;
        end
      end
      ST_HOLD: begin
        if (tmr_done) state_d = ST_ACK;
      end
      ST_ACK: begin
        state_d  = ST_DBG_IDLE;
        pend_d   = 1'b0;
        tmr_load = 1'b1;
        tmr_val  = L_HOLDOFF;
      end
      ST_DBG_IDLE: begin
        // A request seen here is latched for one cycle before SETUP starts.
        if (pend_q) begin
          state_d  = ST_SETUP;
          pend_d   = 1'b0;
          tmr_load = 1'b1;
          tmr_val  = L_SETUP;
        end else if (dbg_req) begin
          pend_d  = 1'b1;
          we_d    = dbg_we;
          addr_d  = dbg_addr;
          wdata_d = dbg_wdata;
        end else if (tmr_done) begin
          state_d = ST_CORE;
        end
      end
      default: state_d = ST_CORE;
    endcase

    // Outputs are decoded from the next state so they line up with it.
    if (state_d == ST_CORE || state_d == ST_HALT) begin
      cart_a_d    = core_a;
      cart_dout_d = core_dout;
      cart_rd_d   = core_rd;
      cart_wr_d   = core_wr;
      cart_oe_d   = core_wr;
      cart_cs_d   = (core_a >= CART_RAM_BASE) && (core_rd || core_wr);
    end else begin
      cart_a_d    = addr_d;
      cart_dout_d = wdata_d;
      cart_rd_d   = (state_d == ST_STROBE) && !we_d;
      cart_wr_d   = (state_d == ST_STROBE) && we_d;
      cart_oe_d   = we_d && (state_d == ST_SETUP || state_d == ST_STROBE || state_d == ST_HOLD);
      cart_cs_d   = (state_d == ST_STROBE) && (addr_d >= CART_RAM_BASE);
    end
    ack_d  = (state_d == ST_ACK);
    halt_d = (state_d != ST_CORE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_CORE;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      pend_q      <= 1'b0;
      rdata_q     <= '0;
      ack_q       <= 1'b0;
      halt_q      <= 1'b0;
      cart_a_q    <= '0;
      cart_dout_q <= '0;
      cart_oe_q   <= 1'b0;
      cart_rd_q   <= 1'b0;
      cart_wr_q   <= 1'b0;
      cart_cs_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      pend_q      <= pend_d;
      rdata_q     <= rdata_d;
      ack_q       <= ack_d;
      halt_q      <= halt_d;
      cart_a_q    <= cart_a_d;
      cart_dout_q <= cart_dout_d;
      cart_oe_q   <= cart_oe_d;
      cart_rd_q   <= cart_rd_d;
      cart_wr_q   <= cart_wr_d;
      cart_cs_q   <= cart_cs_d;
    end
  end

  assign core_din  = cart_din;
  assign core_halt = halt_q;
  assign dbg_ack   = ack_q;
  assign dbg_rdata = rdata_q;
  assign cart_a    = cart_a_q;
  assign cart_dout = cart_dout_q;
  assign cart_oe   = cart_oe_q;
  assign cart_rd   = cart_rd_q;
  assign cart_wr   = cart_wr_q;
  assign cart_cs   = cart_cs_q;

endmodule

// File: tb/tb_cart_bus_arbiter.sv
// tb/tb_cart_bus_arbiter.sv - randomized self-checking bench for cart_bus_arbiter
module tb_cart_bus_arbiter;

  localparam int P_SETTLE  = 2;
  localparam int P_SETUP   = 2;
  localparam int P_STROBE  = 4;
  localparam int P_HOLD    = 1;
  localparam int P_HOLDOFF = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] core_a;
  logic [7:0]  core_dout;
  logic        core_rd, core_wr;
  logic [7:0]  core_din;
  logic        core_halt;
  logic        dbg_req, dbg_we;
  logic [15:0] dbg_addr;
  logic [7:0]  dbg_wdata;
  logic        dbg_ack;
  logic [7:0]  dbg_rdata;
  logic [15:0] cart_a;
  logic [7:0]  cart_dout;
  logic        cart_oe;
  logic [7:0]  cart_din;
  logic        cart_rd, cart_wr, cart_cs;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_rdata = 8'h00;

  int   r_ack_idx, r_ack_cnt, r_rd_cnt, r_wr_cnt, r_cs_cnt, r_oe_cnt, r_dout_bad, r_halt_drop;
  logic r_rd_at [0:7];

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_byte(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h7B;
  endfunction

  assign cart_din = rom_byte(cart_a);

  cart_bus_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .core_a    (core_a),
    .core_dout (core_dout),
    .core_rd   (core_rd),
    .core_wr   (core_wr),
    .core_din  (core_din),
    .core_halt (core_halt),
    .dbg_req   (dbg_req),
    .dbg_we    (dbg_we),
    .dbg_addr  (dbg_addr),
    .dbg_wdata (dbg_wdata),
    .dbg_ack   (dbg_ack),
    .dbg_rdata (dbg_rdata),
    .cart_a    (cart_a),
    .cart_dout (cart_dout),
    .cart_oe   (cart_oe),
    .cart_din  (cart_din),
    .cart_rd   (cart_rd),
    .cart_wr   (cart_wr),
    .cart_cs   (cart_cs)
  );

  // Index k is observed at the falling edge after the (k+1)th rising edge following the request.
  task automatic run_req(input logic we, input logic [15:0] addr, input logic [7:0] wd,
                         input int busy_n, input bit stop_at_ack);
    @(negedge clk);
    dbg_we = we; dbg_addr = addr; dbg_wdata = wd; dbg_req = 1'b1;
    if (busy_n > 0) begin core_rd = 1'b1; core_a = 16'h0200; end
    r_ack_idx = -1; r_ack_cnt = 0; r_rd_cnt = 0; r_wr_cnt = 0; r_cs_cnt = 0;
    r_oe_cnt = 0; r_dout_bad = 0; r_halt_drop = -1;
    for (int k = 0; k < 8; k++) r_rd_at[k] = 1'bx;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (busy_n > 0 && k == busy_n) core_rd = 1'b0;
      if (k < 8) r_rd_at[k] = cart_rd;
      if (k > busy_n && cart_rd) r_rd_cnt++;
      if (cart_wr) r_wr_cnt++;
      if (cart_cs) r_cs_cnt++;
      if (cart_oe) begin
        r_oe_cnt++;
        if (cart_dout !== wd) r_dout_bad++;
      end
      if (!core_halt && r_halt_drop < 0) r_halt_drop = k;
      if (dbg_ack) begin
        if (r_ack_idx < 0) r_ack_idx = k;
        r_ack_cnt++;
        dbg_req = 1'b0;
        if (stop_at_ack) break;
      end
      if (r_halt_drop >= 0) break;
    end
    dbg_req = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #1;
    total++; if (core_halt !== 1'b0) begin bad++; $display("FAIL reset_halt: got %0b want 0", core_halt); end
    total++; if (dbg_ack !== 1'b0) begin bad++; $display("FAIL reset_ack: got %0b want 0", dbg_ack); end
    total++; if (dbg_rdata !== 8'h00) begin bad++; $display("FAIL reset_rdata: got %0h want 0", dbg_rdata); end
    total++; if (cart_a !== 16'h0000) begin bad++; $display("FAIL reset_cart_a: got %0h want 0", cart_a); end
    total++; if ({cart_oe, cart_rd, cart_wr, cart_cs} !== 4'b0000)
      begin bad++; $display("FAIL reset_strobes: got %b want 0000", {cart_oe, cart_rd, cart_wr, cart_cs}); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_read_idle;
    run_req(1'b0, 16'h0134, 8'h00, 0, 1'b0);
    exp_rdata = 8'h4E;
    total++; if (r_ack_idx !== P_SETTLE + P_SETUP + P_STROBE + P_HOLD)
      begin bad++; $display("FAIL rd_ack_latency: got %0d want %0d", r_ack_idx, P_SETTLE + P_SETUP + P_STROBE + P_HOLD); end
    total++; if (r_ack_cnt !== 1) begin bad++; $display("FAIL rd_ack_pulses: got %0d want 1", r_ack_cnt); end
    total++; if (r_rd_cnt !== P_STROBE) begin bad++; $display("FAIL rd_strobe_width: got %0d want %0d", r_rd_cnt, P_STROBE); end
    total++; if (r_cs_cnt !== 0) begin bad++; $display("FAIL rd_cs: got %0d want 0", r_cs_cnt); end
    total++; if (dbg_rdata !== exp_rdata) begin bad++; $display("FAIL rd_data: got %0h want %0h", dbg_rdata, exp_rdata); end
    total++; if (r_halt_drop !== r_ack_idx + 1 + P_HOLDOFF)
      begin bad++; $display("FAIL rd_halt_drop: got %0d want %0d", r_halt_drop, r_ack_idx + 1 + P_HOLDOFF); end
  endtask

  task automatic test_write;
    run_req(1'b1, 16'hA005, 8'h5A, 0, 1'b0);
    total++; if (r_wr_cnt !== P_STROBE) begin bad++; $display("FAIL wr_strobe_width: got %0d want %0d", r_wr_cnt, P_STROBE); end
    total++; if (r_cs_cnt !== P_STROBE) begin bad++; $display("FAIL wr_cs_width: got %0d want %0d", r_cs_cnt, P_STROBE); end
    total++; if (r_oe_cnt !== P_SETUP + P_STROBE + P_HOLD)
      begin bad++; $display("FAIL wr_oe_span: got %0d want %0d", r_oe_cnt, P_SETUP + P_STROBE + P_HOLD); end
    total++; if (r_dout_bad !== 0) begin bad++; $display("FAIL wr_dout: got %0d bad cycles want 0", r_dout_bad); end
    total++; if (r_rd_cnt !== 0) begin bad++; $display("FAIL wr_no_rd: got %0d want 0", r_rd_cnt); end
    total++; if (dbg_rdata !== exp_rdata) begin bad++; $display("FAIL wr_rdata_kept: got %0h want %0h", dbg_rdata, exp_rdata); end
  endtask

  task automatic test_core_busy;
    int nb;
    nb = 3;
    run_req(1'b0, 16'h4000, 8'h00, nb, 1'b0);
    exp_rdata = rom_byte(16'h4000);
    for (int k = 0; k <= nb + 1; k++) begin
      total++; if (r_rd_at[k] !== (k <= nb))
        begin bad++; $display("FAIL busy_passthru[%0d]: got %b want %b", k, r_rd_at[k], (k <= nb)); end
    end
    total++; if (r_ack_idx !== nb + P_SETTLE + P_SETUP + P_STROBE + P_HOLD)
      begin bad++; $display("FAIL busy_ack_latency: got %0d want %0d", r_ack_idx, nb + P_SETTLE + P_SETUP + P_STROBE + P_HOLD); end
    total++; if (r_rd_cnt !== P_STROBE) begin bad++; $display("FAIL busy_strobe_width: got %0d want %0d", r_rd_cnt, P_STROBE); end
    total++; if (dbg_rdata !== exp_rdata) begin bad++; $display("FAIL busy_rdata: got %0h want %0h", dbg_rdata, exp_rdata); end
    core_a = 16'h0000;
  endtask

  task automatic test_back_to_back;
    logic [15:0] a2;
    run_req(1'b0, 16'h1234, 8'h00, 0, 1'b1);
    exp_rdata = rom_byte(16'h1234);
    total++; if (r_ack_idx !== P_SETTLE + P_SETUP + P_STROBE + P_HOLD)
      begin bad++; $display("FAIL b2b_first_ack: got %0d want %0d", r_ack_idx, P_SETTLE + P_SETUP + P_STROBE + P_HOLD); end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++; if (core_halt !== 1'b1) begin bad++; $display("FAIL b2b_halt_gap: got %0b want 1", core_halt); end
    end
    a2 = 16'(16'hA000 + $urandom_range(0, 255));
    run_req(1'b0, a2, 8'h00, 0, 1'b0);
    exp_rdata = rom_byte(a2);
    total++; if (r_ack_idx !== P_SETUP + P_STROBE + P_HOLD + 1)
      begin bad++; $display("FAIL b2b_second_ack: got %0d want %0d", r_ack_idx, P_SETUP + P_STROBE + P_HOLD + 1); end
    total++; if (r_halt_drop !== r_ack_idx + 1 + P_HOLDOFF)
      begin bad++; $display("FAIL b2b_halt_held: got %0d want %0d", r_halt_drop, r_ack_idx + 1 + P_HOLDOFF); end
    total++; if (r_cs_cnt !== P_STROBE) begin bad++; $display("FAIL b2b_cs: got %0d want %0d", r_cs_cnt, P_STROBE); end
    total++; if (dbg_rdata !== exp_rdata) begin bad++; $display("FAIL b2b_rdata: got %0h want %0h", dbg_rdata, exp_rdata); end
  endtask

  task automatic test_random;
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wd;
    int          nb;
    for (int it = 0; it < 8; it++) begin
      we   = 1'($urandom_range(0, 1));
      addr = 16'($urandom);
      wd   = 8'($urandom);
      nb   = $urandom_range(0, 3);
      run_req(we, addr, wd, nb, 1'b0);
      if (!we) exp_rdata = rom_byte(addr);
      total++; if (r_ack_idx !== nb + P_SETTLE + P_SETUP + P_STROBE + P_HOLD)
        begin bad++; $display("FAIL rnd%0d_ack: got %0d want %0d", it, r_ack_idx, nb + P_SETTLE + P_SETUP + P_STROBE + P_HOLD); end
      total++; if (dbg_rdata !== exp_rdata)
        begin bad++; $display("FAIL rnd%0d_rdata: got %0h want %0h", it, dbg_rdata, exp_rdata); end
      total++; if ({r_rd_cnt, r_wr_cnt} !== {(we ? 0 : P_STROBE), (we ? P_STROBE : 0)})
        begin bad++; $display("FAIL rnd%0d_strobes: got rd=%0d wr=%0d want we=%0b", it, r_rd_cnt, r_wr_cnt, we); end
      total++; if (r_cs_cnt !== ((addr >= 16'hA000) ? P_STROBE : 0))
        begin bad++; $display("FAIL rnd%0d_cs: got %0d addr %0h", it, r_cs_cnt, addr); end
      total++; if (r_oe_cnt !== (we ? P_SETUP + P_STROBE + P_HOLD : 0) || r_dout_bad !== 0)
        begin bad++; $display("FAIL rnd%0d_oe: got %0d (bad dout %0d) want we=%0b", it, r_oe_cnt, r_dout_bad, we); end
      core_a = 16'h0000;
    end
  endtask

  task automatic test_reset_mid;
    int acks;
    @(negedge clk);
    dbg_we = 1'b0; dbg_addr = 16'h0150; dbg_req = 1'b1;
    for (int k = 0; k < 6; k++) @(negedge clk);
    total++; if (cart_rd !== 1'b1) begin bad++; $display("FAIL rstmid_in_strobe: got %0b want 1", cart_rd); end
    rst_n = 1'b0;
    dbg_req = 1'b0;
    exp_rdata = 8'h00;
    #1;
    total++; if (cart_rd !== 1'b0) begin bad++; $display("FAIL rstmid_rd: got %0b want 0", cart_rd); end
    total++; if (core_halt !== 1'b0) begin bad++; $display("FAIL rstmid_halt: got %0b want 0", core_halt); end
    total++; if (dbg_rdata !== exp_rdata) begin bad++; $display("FAIL rstmid_rdata: got %0h want %0h", dbg_rdata, exp_rdata); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    acks = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (dbg_ack) acks++;
    end
    total++; if (acks !== 0) begin bad++; $display("FAIL rstmid_no_ack: got %0d want 0", acks); end
    core_wr = 1'b1; core_a = 16'hA010; core_dout = 8'h77;
    @(negedge clk);
    total++; if ({cart_wr, cart_cs, cart_oe, cart_rd} !== 4'b1110)
      begin bad++; $display("FAIL rstmid_passthru_strobes: got %b want 1110", {cart_wr, cart_cs, cart_oe, cart_rd}); end
    total++; if ({cart_a, cart_dout} !== {16'hA010, 8'h77})
      begin bad++; $display("FAIL rstmid_passthru_bus: got %0h/%0h want a010/77", cart_a, cart_dout); end
    total++; if (core_halt !== 1'b0) begin bad++; $display("FAIL rstmid_passthru_halt: got %0b want 0", core_halt); end
    core_wr = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; core_a = '0; core_dout = '0; core_rd = 1'b0; core_wr = 1'b0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    test_reset;
    test_read_idle;
    test_write;
    test_core_busy;
    test_back_to_back;
    test_random;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cart_bus_arbiter.md
# cart_bus_arbiter

Shares the external cartridge bus (address, data, RD/WR/CS strobes) between the Game Boy core and a debug host such as the UART command path. The core owns the bus by default. A debug request halts the core clock, runs one timed cartridge read or write, returns the result, then releases the bus back to the core. It sits between the core's bus ports and the top-level `gb_a`/`gb_d`/`gb_rd`/`gb_wr`/`gb_cs` pins, and it replaces the ad-hoc halt toggle.

## Interface
Parameters:
- `HALT_SETTLE`, 2: consecutive cycles with core strobes idle required before taking the bus.
- `SETUP_CYCLES`, 2: cycles the address (and write data) is stable before the strobe.
- `STROBE_CYCLES`, 4: RD/WR strobe width; read data is sampled on the last strobe cycle.
- `HOLD_CYCLES`, 1: cycles the address/data is held after the strobe.
- `HOLDOFF_CYCLES`, 8: cycles the bus stays debug-owned after an ack while waiting for another request.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock
- `rst_n`  in  1  async active-low reset
- `core_a`  in  16  core address
- `core_dout`  in  8  core write data
- `core_rd`  in  1  core read strobe, active high
- `core_wr`  in  1  core write strobe, active high
- `core_din`  out  8  read data to core
- `core_halt`  out  1  gates the core clock while high
- `dbg_req`  in  1  debug access request, level
- `dbg_we`  in  1  1 = write, 0 = read
- `dbg_addr`  in  16  debug address
- `dbg_wdata`  in  8  debug write data
- `dbg_ack`  out  1  one-cycle completion pulse
- `dbg_rdata`  out  8  read result, valid from `dbg_ack` until the next ack
- `cart_a`  out  16  bus address
- `cart_dout`  out  8  bus write data
- `cart_oe`  out  1  data pin drive enable
- `cart_din`  in  8  bus read data
- `cart_rd`  out  1  read strobe, active high
- `cart_wr`  out  1  write strobe, active high
- `cart_cs`  out  1  RAM chip select, active high

## Operation
- **States:** CORE, HALT, SETUP, STROBE, HOLD, ACK, DBG_IDLE.
- **CORE:**
  - `cart_a`, `cart_dout`, `cart_rd` and `cart_wr` are registered copies of the core signals, with one cycle of latency.
  - `cart_oe` is the registered `core_wr`.
  - `cart_cs` is registered `(core_a >= 16'hA000) & (core_rd | core_wr)`.
  - `core_din` is `cart_din` combinationally, in every state.
  - If `dbg_req` is sampled high, go to HALT.
- **HALT:**
  - `core_halt` is 1 from here until the return to CORE.
  - Count cycles where `core_rd == 0 && core_wr == 0`; any active strobe resets the count.
  - When the count reaches `HALT_SETTLE`, latch `dbg_we`/`dbg_addr`/`dbg_wdata` and go to SETUP.
  - While in HALT, cart outputs keep following the core.
- **SETUP, `SETUP_CYCLES` cycles:**
  - `cart_a` = latched address, strobes low.
  - For a write: `cart_dout` = latched data and `cart_oe` = 1.
- **STROBE, `STROBE_CYCLES` cycles:**
  - Asserts `cart_rd` (read) or `cart_wr` (write).
  - `cart_cs` = latched address ≥ `A000`.
  - On the last cycle of a read, `cart_din` is captured into `dbg_rdata`.
- **HOLD, `HOLD_CYCLES` cycles:** strobes and `cart_cs` low; address and, for a write, `cart_oe`/`cart_dout` stay held.
- **ACK, 1 cycle:** `dbg_ack` = 1; `cart_oe` = 0; then go to DBG_IDLE.
- **DBG_IDLE:**
  - If `dbg_req` is high, go directly to SETUP with no re-halt (inputs latched).
  - After `HOLDOFF_CYCLES` without a request, go to CORE and drop `core_halt`.
- **Handshake:** the requester holds `dbg_req` and its inputs until it sees `dbg_ack`, then deasserts `dbg_req` within 1 cycle. The `dbg_req` level during ACK is ignored.
- **`dbg_req` dropped mid-access:** the access completes and `dbg_ack` still pulses.
- **Write-back:** `dbg_rdata` is unchanged by debug writes.

## Timing
- **Reset values:**
  - State CORE; `core_halt`, `dbg_ack` = 0; `dbg_rdata` = 0.
  - `cart_a` = 0, `cart_dout` = 0; `cart_oe`, `cart_rd`, `cart_wr`, `cart_cs` = 0.
  - `rst_n` low mid-access forces all of these immediately and aborts without an ack.
- **Latency with defaults and the core idle:** `dbg_ack` is high in the cycle that starts 9 edges after the edge that sampled `dbg_req` (HALT_SETTLE + SETUP + STROBE + HOLD).
- **Back-to-back access from DBG_IDLE:** ack comes `SETUP_CYCLES + STROBE_CYCLES + HOLD_CYCLES + 1` edges after the request is sampled.
- **Counter width:** all counters are sized `$clog2(max parameter + 1)`; each parameter is ≥ 1.

## Structure
- **Package `cart_bus_pkg`:** state enum, `CART_RAM_BASE = 16'hA000`, default timing constants.
- **Sub-module `phase_timer`:** loadable down-counter with a `done` flag, shared by every timed state.

## Test plan
- **Debug read, core idle:** `dbg_req`, `dbg_we` = 0, addr `0x0134`, bus model returns `0x4E` → `cart_rd` high exactly 4 cycles; `cart_cs` = 0; `dbg_ack` at edge 9; `dbg_rdata` = `0x4E`; `core_halt` drops 8 cycles after DBG_IDLE is entered.
- **Debug write to `0xA005` data `0x5A`:** `cart_cs` = 1 and `cart_wr` = 1 for 4 cycles; `cart_oe` = 1 from SETUP through HOLD; `cart_dout` = `0x5A`; `dbg_rdata` unchanged.
- **Core strobe active when `dbg_req` rises:** `core_rd` held 3 more cycles → SETUP begins only after 2 idle cycles; the core access passes through to `cart_rd` unmodified.
- **Two requests 2 cycles apart after an ack:** the second access starts from DBG_IDLE with no return to CORE; `core_halt` stays 1 throughout.
- **`rst_n` low during STROBE:** `cart_rd` and `core_halt` go 0 asynchronously; no `dbg_ack`; after release the core pass-through works.
